zone_color_accum: RTL and testbench
===================================

Name: zone_color_accum

Overview:
- Sits directly downstream of the pixel down-sampler. Consumes its averaged RGB565 sample stream (one pulse per down-sampled pixel).
- Accumulates the top band of each frame into ZONES equal-width column zones and computes a per-zone mean colour.
- Streams the zone means as RGB888 over a valid/ready interface to the LED-strip driver that produces the ambient-lamp output.

Parameters:
- SAMP_H, 128: down-sampled samples per line (must equal 2^(ZONES_LOG2+ZONE_W_LOG2)).
- ZONES_LOG2, 3: log2 of the zone count (ZONES = 8).
- ZONE_W_LOG2, 4: log2 of samples per zone per line (16).
- ROWS_LOG2, 5: log2 of down-sampled lines in the top band (32).

Ports:
- video_clk  in  1  pixel clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse marking the start of a new frame (before its first sample).
- pdata_i  in  16  RGB565 sample, {R[15:11], G[10:5], B[4:0]}.
- data_val  in  1  pdata_i valid, single-cycle pulses.
- out_valid  out  1  zone result valid.
- out_ready  in  1  downstream accepts the result when out_valid && out_ready.
- out_zone  out  ZONES_LOG2  zone index of the current result.
- out_rgb  out  24  zone mean colour, {R8, G8, B8}.
- frame_done  out  1  one-cycle pulse after the last zone of a frame is accepted.
- overrun  out  1  one-cycle pulse when a frame_start arrives during DRAIN.

Behaviour:
- Reset: rst_n is asynchronous and active-low. While rst_n is low: out_valid=0, out_zone=0, out_rgb=0, frame_done=0, overrun=0, state=WAIT_FRAME, counters and accumulators cleared. Reset asserted mid-frame or mid-drain aborts that work with no further output.
- States:
  - WAIT_FRAME: ignore data_val. On frame_start, clear all accumulators, col_cnt and row_cnt, then go to ACCUM.
  - ACCUM: each accepted data_val adds R5, G6 and B5 into zone accumulator col_cnt[ZONE_W_LOG2+ZONES_LOG2-1 : ZONE_W_LOG2].
    - col_cnt wraps at SAMP_H-1 and row_cnt then increments.
    - When the sample with row=2^ROWS_LOG2-1 and col=SAMP_H-1 is accepted at cycle T, go to DRAIN.
    - out_valid=1 with zone 0 at cycle T+1; that sample is included in zone ZONES-1.
  - DRAIN: present zones 0..ZONES-1 in order.
    - out_zone and out_rgb stay stable while out_valid && !out_ready.
    - On a handshake, the next zone appears in the following cycle (no bubble).
    - After zone ZONES-1 handshakes: out_valid=0, frame_done=1 for one cycle, go to WAIT_FRAME.
    - data_val in DRAIN is ignored.
- frame_start in ACCUM: restart (clear accumulators and counters, stay in ACCUM). A data_val in the same cycle is counted as col 0, row 0 of the new frame.
- frame_start in DRAIN: ignored, overrun pulses for one cycle, and that frame produces no output. A frame_start coinciding with the final handshake is also treated as overrun.
- Arithmetic:
  - Accumulator widths are 5+ZONE_W_LOG2+ROWS_LOG2 bits for R and B, and 6+ZONE_W_LOG2+ROWS_LOG2 bits for G. They cannot overflow.
  - Means are formed by right shift by ZONE_W_LOG2+ROWS_LOG2 (truncating), giving r5, g6 and b5.
  - Expansion to 8 bits: R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}.
  - Means may be registered in DRAIN; out_valid must still satisfy the T+1 latency.
- Samples after the band (rows at or beyond 2^ROWS_LOG2) are never accumulated.

Test Plan:
- Reset then frame_start, 32x128 samples of 16'hF800 -> out_valid at T+1, zones 0..7 each out_rgb=24'hFF0000, then one frame_done pulse.
- Samples with R5=4*zone, G=0, B=0 -> zone 3 out_rgb=24'h630000, zone 7 (R5=28) out_rgb=24'hE70000.
- Hold out_ready=0 for 10 cycles at zone 2, then toggle out_ready randomly -> out_zone and out_rgb stable while stalled, zones emitted 0..7 without gaps or repeats.
- frame_start pulse during DRAIN -> overrun pulses once, drain completes unchanged. A second frame_start after frame_done starts a fresh accumulation.
- frame_start mid-ACCUM (row 10), then a full band of 16'h07E0 -> out_rgb=24'h00FF00 for all zones (earlier data discarded).
- rst_n low for 1 cycle during DRAIN at zone 4 -> all outputs 0 immediately, no frame_done, samples ignored until the next frame_start.

Source files
------------

// File: rtl/zone_color_accum.sv
// Zone colour accumulator: sums the top band of each frame into equal-width column
// zones and streams the per-zone mean colours as RGB888 over valid/ready.
module zone_color_accum #(
  parameter int unsigned SAMP_H      = 128,
  parameter int unsigned ZONES_LOG2  = 3,
  parameter int unsigned ZONE_W_LOG2 = 4,
  parameter int unsigned ROWS_LOG2   = 5
) (
  input  logic                  video_clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [15:0]           pdata_i,
  input  logic                  data_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ZONES_LOG2-1:0] out_zone,
  output logic [23:0]           out_rgb,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int unsigned ZONES = 2 ** ZONES_LOG2;
  localparam int unsigned COL_W = ZONES_LOG2 + ZONE_W_LOG2;
  localparam int unsigned SHIFT = ZONE_W_LOG2 + ROWS_LOG2;
  localparam int unsigned RB_W  = 5 + SHIFT;
  localparam int unsigned G_W   = 6 + SHIFT;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SAMP_H - 1);

  typedef enum logic [1:0] {WAIT_FRAME, ACCUM, DRAIN} state_t;

  state_t                 state;
  logic [COL_W-1:0]       col_cnt;
  logic [ROWS_LOG2-1:0]   row_cnt;
  logic [RB_W-1:0]        acc_r [ZONES];
  logic [G_W-1:0]         acc_g [ZONES];
  logic [RB_W-1:0]        acc_b [ZONES];
  logic [RB_W-1:0]        acc_r_nxt [ZONES];
  logic [G_W-1:0]         acc_g_nxt [ZONES];
  logic [RB_W-1:0]        acc_b_nxt [ZONES];
  logic [ZONES_LOG2-1:0]  zone_sel;
  logic [ZONES_LOG2-1:0]  nxt_zone;
  logic                   hit;

  // Truncating mean (drop SHIFT LSBs) followed by MSB replication to 8 bits.
  function automatic logic [23:0] expand(input logic [RB_W-1:0] r,
                                         input logic [G_W-1:0]  g,
                                         input logic [RB_W-1:0] b);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = r[RB_W-1 -: 5];
    g6 = g[G_W-1 -: 6];
    b5 = b[RB_W-1 -: 5];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

  // A frame_start in ACCUM restarts the band; a coincident sample becomes col 0 of it.
  always_comb begin
    hit      = 1'b0;
    zone_sel = frame_start ? '0 : col_cnt[COL_W-1 -: ZONES_LOG2];
    for (int unsigned z = 0; z < ZONES; z++) begin
      hit          = data_val && (zone_sel == ZONES_LOG2'(z));
      acc_r_nxt[z] = (frame_start ? '0 : acc_r[z]) + (hit ? RB_W'(pdata_i[15:11]) : '0);
      acc_g_nxt[z] = (frame_start ? '0 : acc_g[z]) + (hit ? G_W'(pdata_i[10:5])   : '0);
      acc_b_nxt[z] = (frame_start ? '0 : acc_b[z]) + (hit ? RB_W'(pdata_i[4:0])   : '0);
    end
  end

  assign nxt_zone = out_zone + 1'b1;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_FRAME;
      col_cnt    <= '0;
      row_cnt    <= '0;
      out_valid  <= 1'b0;
      out_zone   <= '0;
      out_rgb    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int unsigned z = 0; z < ZONES; z++) begin
        acc_r[z] <= '0;
        acc_g[z] <= '0;
        acc_b[z] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          if (frame_start) begin
            col_cnt <= '0;
            row_cnt <= '0;
            for (int unsigned z = 0; z < ZONES; z++) begin
              acc_r[z] <= '0;
              acc_g[z] <= '0;
              acc_b[z] <= '0;
            end
            state <= ACCUM;
          end
        end
        ACCUM: begin
          for (int unsigned z = 0; z < ZONES; z++) begin
            acc_r[z] <= acc_r_nxt[z];
            acc_g[z] <= acc_g_nxt[z];
            acc_b[z] <= acc_b_nxt[z];
          end
          if (frame_start) begin
            col_cnt <= data_val ? COL_W'(1) : '0;
            row_cnt <= '0;
          end else if (data_val) begin
            col_cnt <= col_cnt + 1'b1;
            if (col_cnt == COL_LAST) begin
              row_cnt <= row_cnt + 1'b1;
              if (row_cnt == '1) begin
                // Zone 0 mean taken from the post-update sums so it is valid one cycle later.
                state     <= DRAIN;
                out_valid <= 1'b1;
                out_zone  <= '0;
                out_rgb   <= expand(acc_r_nxt[0], acc_g_nxt[0], acc_b_nxt[0]);
              end
            end
          end
        end
        DRAIN: begin
          overrun <= frame_start;
          if (out_ready) begin
            if (out_zone == '1) begin
              out_valid  <= 1'b0;
              out_zone   <= '0;
              out_rgb    <= '0;
              frame_done <= 1'b1;
              state      <= WAIT_FRAME;
            end else begin
              out_zone <= nxt_zone;
              out_rgb  <= expand(acc_r[nxt_zone], acc_g[nxt_zone], acc_b[nxt_zone]);
            end
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: tb/tb_zone_color_accum.sv
// Directed bench for zone_color_accum: table of full-band frames with hand-computed
// zone colours, plus stall, overrun, mid-band restart and mid-drain reset sequences.
module tb_zone_color_accum;

  logic        video_clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [15:0] pdata_i;
  logic        data_val;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_zone;
  logic [23:0] out_rgb;
  logic        frame_done;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  zone_color_accum #(
    .SAMP_H(128),
    .ZONES_LOG2(3),
    .ZONE_W_LOG2(4),
    .ROWS_LOG2(5)
  ) dut (
    .video_clk(video_clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .pdata_i(pdata_i),
    .data_val(data_val),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_zone(out_zone),
    .out_rgb(out_rgb),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 video_clk = ~video_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string            name;
    int               mode;        // 0 const, 1 R5=4*zone, 2 base on odd cols, 3 G6=row
    logic [15:0]      base;
    int               ready_mode;  // 0 always ready, 1 stall at zone 2 then random
    int               os_at;       // zone index at which to inject frame_start (-1 none)
    logic [7:0][23:0] exp;         // exp[z] = expected out_rgb of zone z
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] pix_of(input int mode, input logic [15:0] base,
                                         input int row, input int col);
    logic [4:0] r5;
    logic [5:0] g6;
    case (mode)
      1: begin r5 = 5'(4 * (col / 16)); return {r5, 11'b0}; end
      2: return (col % 2 == 1) ? base : 16'h0000;
      3: begin g6 = 6'(row); return {5'b0, g6, 5'b0}; end
      default: return base;
    endcase
  endfunction

  // Entered and left just after a falling edge.
  task automatic send_frame(input int mode, input logic [15:0] base, input bit fs_with_first);
    if (!fs_with_first) begin
      frame_start = 1'b1;
      @(negedge video_clk);
      frame_start = 1'b0;
    end
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 128; c++) begin
        frame_start = fs_with_first && r == 0 && c == 0;
        data_val    = 1'b1;
        pdata_i     = pix_of(mode, base, r, c);
        if (r == 31 && c == 127) check("valid_before_last", 32'(out_valid), 32'd0);
        @(negedge video_clk);
      end
    end
    frame_start = 1'b0;
    data_val    = 1'b0;
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_zone0", 32'(out_zone), 32'd0);
  endtask

  task automatic drain(input int ready_mode, input int os_at, input int abort_at,
                       input logic [7:0][23:0] exp);
    int          idx = 0;
    int          cycles = 0;
    int          stall_cnt = 0;
    int          ov_cnt = 0;
    bit          prev_stall = 0;
    bit          os_done = 0;
    bit          rdy;
    logic [2:0]  snap_zone = '0;
    logic [23:0] snap_rgb = '0;
    while (idx < 8 && cycles < 300) begin
      if (abort_at >= 0 && idx == abort_at) return;
      if (overrun) ov_cnt++;
      check("drain_valid", 32'(out_valid), 32'd1);
      if (prev_stall) begin
        check("stall_zone_stable", 32'(out_zone), 32'(snap_zone));
        check("stall_rgb_stable", 32'(out_rgb), 32'(snap_rgb));
      end
      if (ready_mode == 1 && idx == 2 && stall_cnt < 10) begin
        rdy = 1'b0;
        stall_cnt++;
      end else if (ready_mode == 1) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b1;
      end
      out_ready   = rdy;
      frame_start = (idx == os_at) && !os_done;
      if (frame_start) os_done = 1;
      if (rdy) begin
        check("zone_order", 32'(out_zone), 32'(idx));
        check("zone_rgb", 32'(out_rgb), 32'(exp[idx]));
        idx++;
        prev_stall = 0;
      end else begin
        prev_stall = 1;
        snap_zone  = out_zone;
        snap_rgb   = out_rgb;
      end
      @(negedge video_clk);
      frame_start = 1'b0;
      cycles++;
    end
    out_ready = 1'b1;
    if (idx < 8) begin
      check("drain_timeout", 32'(idx), 32'd8);
      return;
    end
    if (overrun) ov_cnt++;
    check("done_pulse", 32'(frame_done), 32'd1);
    check("valid_after_done", 32'(out_valid), 32'd0);
    @(negedge video_clk);
    if (overrun) ov_cnt++;
    check("done_width", 32'(frame_done), 32'd0);
    check("overrun_count", 32'(ov_cnt), (os_at >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int seen;
    vecs[0] = '{"red_full",  0, 16'hF800, 0, -1, {8{24'hFF0000}}};
    vecs[1] = '{"red_grad",  1, 16'h0000, 0, -1,
                {24'hE70000, 24'hC60000, 24'hA50000, 24'h840000,
                 24'h630000, 24'h420000, 24'h210000, 24'h000000}};
    vecs[2] = '{"stall",     0, 16'h07E0, 1, -1, {8{24'h00FF00}}};
    vecs[3] = '{"blue_odd",  2, 16'h001F, 0,  3, {8{24'h00007B}}};
    vecs[4] = '{"green_row", 3, 16'h0000, 0,  7, {8{24'h003C00}}};
    vecs[5] = '{"white",     0, 16'hFFFF, 1, -1, {8{24'hFFFFFF}}};
    vecs[6] = '{"green",     0, 16'h07E0, 0, -1, {8{24'h00FF00}}};

    rst_n = 1'b0; frame_start = 1'b0; data_val = 1'b0; pdata_i = '0; out_ready = 1'b1;
    repeat (3) @(negedge video_clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_zone", 32'(out_zone), 32'd0);
    check("rst_rgb", 32'(out_rgb), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge video_clk);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].mode, vecs[v].base, 1'b0);
      drain(vecs[v].ready_mode, vecs[v].os_at, -1, vecs[v].exp);
      repeat (2) @(negedge video_clk);
    end

    // Restart mid-band at row 10; restart coincides with the first green sample.
    frame_start = 1'b1;
    @(negedge video_clk);
    frame_start = 1'b0;
    for (int i = 0; i < 10 * 128; i++) begin
      data_val = 1'b1;
      pdata_i  = 16'hF81F;
      @(negedge video_clk);
    end
    send_frame(0, 16'h07E0, 1'b1);
    drain(0, -1, -1, vecs[6].exp);

    // Reset in the middle of draining zone 4.
    send_frame(0, 16'hF800, 1'b0);
    drain(0, -1, 4, vecs[0].exp);
    check("pre_reset_zone", 32'(out_zone), 32'd4);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_zone", 32'(out_zone), 32'd0);
    check("async_rst_rgb", 32'(out_rgb), 32'd0);
    @(negedge video_clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 32 * 128 + 4; i++) begin
      data_val = 1'b1;
      pdata_i  = 16'hF800;
      @(negedge video_clk);
      if (out_valid || frame_done) seen++;
    end
    data_val = 1'b0;
    check("ignored_after_reset", 32'(seen), 32'd0);
    send_frame(vecs[6].mode, vecs[6].base, 1'b0);
    drain(vecs[6].ready_mode, vecs[6].os_at, -1, vecs[6].exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
